// File: rtl/xoodoo_absorb.sv
// xoodoo_absorb: sponge absorb front-end for the 3-round Xoodoo permutation.
// Packs 32-bit little-endian message words into 96-bit blocks and applies
// 10*1 padding. Each block is XORed into the running state, and the
// permutation result is chained back into the state. The final state is
// presented as the digest.
// Optional feature: define XOODOO_ABSORB_MSGLEN_EN to add the msg_bytes output.
// msg_bytes is the message length in bytes, latched together with the digest.
module xoodoo_absorb #(
    parameter int         WORD_W      = 32,
    parameter int         BLOCK_WORDS = 3,
    parameter logic [7:0] PAD_FIRST   = 8'h01,
    parameter logic [7:0] PAD_LAST    = 8'h80
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [WORD_W-1:0] in_data,
    input  logic        in_valid,
    input  logic        in_last,
    input  logic [2:0]  in_nbytes,
    output logic        in_ready,
    output logic [WORD_W*BLOCK_WORDS-1:0] perm_state,
    output logic        perm_dv,
    input  logic [WORD_W*BLOCK_WORDS-1:0] perm_out,
    input  logic        perm_out_valid,
    output logic [WORD_W*BLOCK_WORDS-1:0] digest,
    output logic        digest_valid,
    output logic        busy
`ifdef XOODOO_ABSORB_MSGLEN_EN
    ,
    output logic [31:0] msg_bytes
`endif
);

    localparam int BLOCK_W     = WORD_W * BLOCK_WORDS;
    localparam int WORD_BYTES  = WORD_W / 8;
    localparam int BLOCK_BYTES = BLOCK_W / 8;
    localparam logic [1:0] LAST_IDX = 2'(BLOCK_WORDS - 1);
    localparam logic [BLOCK_W-1:0] PAD_BLOCK = {PAD_LAST, {(BLOCK_W-16){1'b0}}, PAD_FIRST};

    typedef enum logic [2:0] {IDLE, COLLECT, ISSUE, WAIT, PAD, DONE} state_t;

    state_t state, next_state;

    logic [BLOCK_W-1:0] s;            // running sponge state
    logic [BLOCK_W-1:0] block;        // block being assembled
    logic [BLOCK_W-1:0] block_upd;    // block with the incoming word merged in
    logic [1:0]         idx;          // next word slot within the block
    logic               pad_pending;  // 12-byte-aligned message still owes a pad block
    logic               msg_done;     // final word has been accepted
    logic               transfer;
    logic               closing;
    logic               pad_fits;
    logic [2:0]         nb_eff;
    logic [3:0]         pad_pos;
    logic [WORD_W-1:0]  word_in;

    // Reset holds in_ready low even though the state register already reads IDLE.
    assign in_ready = rst_n && (state == IDLE || state == COLLECT);
    assign transfer = in_valid && in_ready;
    assign closing  = transfer && (in_last || idx == LAST_IDX);
    assign perm_dv  = (state == ISSUE);
    assign busy     = (state != IDLE) && (state != DONE);

    // Byte count of the incoming word: 4 unless it is the last word, clamped to 4.
    assign nb_eff   = !in_last ? 3'd4 : ((in_nbytes > 3'd4) ? 3'd4 : in_nbytes);
    assign pad_pos  = {idx, 2'b00} + {1'b0, nb_eff};
    assign pad_fits = !(idx == LAST_IDX && nb_eff == 3'd4);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every register
            // samples pre-edge values regardless of block evaluation order.
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so every path assigns next_state and no latch is inferred.
        next_state = state;
        case (state)
            IDLE, COLLECT: begin
                if (closing) begin
                    next_state = ISSUE;
                end else if (transfer) begin
                    next_state = COLLECT;
                end
            end
            ISSUE: next_state = WAIT;
            WAIT: begin
                if (perm_out_valid) begin
                    if (!msg_done) begin
                        next_state = COLLECT;
                    end else if (pad_pending) begin
                        next_state = PAD;
                    end else begin
                        next_state = DONE;
                    end
                end
            end
            PAD:     next_state = ISSUE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Merge the incoming word into the block; on the last word also mask the
    // unused bytes and apply padding if it fits.
    always_comb begin
        word_in   = in_data;
        block_upd = block;
        for (int b = 0; b < WORD_BYTES; b++) begin
            if (b >= int'(nb_eff)) begin
                word_in[8*b +: 8] = 8'h00;
            end
        end
        for (int w = 0; w < BLOCK_WORDS; w++) begin
            if (w == int'(idx)) begin
                block_upd[WORD_W*w +: WORD_W] = word_in;
            end
        end
        if (in_last && pad_fits) begin
            for (int b = 0; b < BLOCK_BYTES; b++) begin
                if (b == int'(pad_pos)) begin
                    block_upd[8*b +: 8] = block_upd[8*b +: 8] ^ PAD_FIRST;
                end
            end
            block_upd[BLOCK_W-1 -: 8] = block_upd[BLOCK_W-1 -: 8] ^ PAD_LAST;
        end
    end

    // Sponge datapath: block assembly, launch, chaining and digest capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the block buffer is explicitly reset because the padding logic
            // relies on unwritten word slots reading as zero.
            s            <= '0;
            block        <= '0;
            idx          <= '0;
            pad_pending  <= 1'b0;
            msg_done     <= 1'b0;
            perm_state   <= '0;
            digest       <= '0;
            digest_valid <= 1'b0;
        end else begin
            digest_valid <= 1'b0;
            case (state)
                IDLE, COLLECT: begin
                    if (transfer) begin
                        block <= block_upd;
                        idx   <= idx + 2'd1;
                        if (in_last) begin
                            msg_done    <= 1'b1;
                            pad_pending <= !pad_fits;
                        end
                        if (closing) begin
                            perm_state <= s ^ block_upd;
                        end
                    end
                end
                WAIT: begin
                    if (perm_out_valid) begin
                        s     <= perm_out;
                        block <= '0;
                        idx   <= '0;
                        // The digest is captured here so it lines up with the
                        // digest_valid pulse in DONE.
                        if (msg_done && !pad_pending) begin
                            digest       <= perm_out;
                            digest_valid <= 1'b1;
                        end
                    end
                end
                PAD: begin
                    block       <= PAD_BLOCK;
                    perm_state  <= s ^ PAD_BLOCK;
                    pad_pending <= 1'b0;
                end
                DONE: begin
                    s        <= '0;
                    msg_done <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef XOODOO_ABSORB_MSGLEN_EN
    logic [31:0] msg_cnt;

    // Running byte count of the message, latched with the digest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msg_cnt   <= '0;
            msg_bytes <= '0;
        end else begin
            if (transfer) begin
                msg_cnt <= msg_cnt + {29'd0, nb_eff};
            end
            if (state == WAIT && perm_out_valid && msg_done && !pad_pending) begin
                msg_bytes <= msg_cnt;
            end
            if (state == DONE) begin
                msg_cnt <= '0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_xoodoo_absorb.sv
// tb_xoodoo_absorb: randomized self-checking bench for xoodoo_absorb.
// The bench stands in for the permutation core with a fixed mixing function.
// It models the sponge at byte level: message, 10*1 padding, then XOR-and-permute
// over 12-byte blocks.
module tb_xoodoo_absorb;

    localparam int CLK_P = 10;

    typedef logic [7:0] byte_q_t[$];

    logic        clk;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic [2:0]  in_nbytes;
    logic        in_ready;
    logic [95:0] perm_state;
    logic        perm_dv;
    logic [95:0] perm_out;
    logic        perm_out_valid;
    logic [95:0] digest;
    logic        digest_valid;
    logic        busy;
`ifdef XOODOO_ABSORB_MSGLEN_EN
    logic [31:0] msg_bytes;
`endif

    xoodoo_absorb dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_last        (in_last),
        .in_nbytes      (in_nbytes),
        .in_ready       (in_ready),
        .perm_state     (perm_state),
        .perm_dv        (perm_dv),
        .perm_out       (perm_out),
        .perm_out_valid (perm_out_valid),
        .digest         (digest),
        .digest_valid   (digest_valid),
        .busy           (busy)
`ifdef XOODOO_ABSORB_MSGLEN_EN
        ,
        .msg_bytes      (msg_bytes)
`endif
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          core_lat = 1;
    bit          gaps_en = 0;
    time         pov_time = 0;
    logic [95:0] exp_perm[$];
    logic [95:0] exp_digest[$];
    logic [31:0] exp_len[$];
    logic [95:0] model_blocks[$];

    initial clk = 1'b0;
    always #(CLK_P/2) clk = ~clk;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Stand-in for the permutation: any fixed, non-trivial mixing function.
    function automatic logic [95:0] perm_f(input logic [95:0] x);
        logic [95:0] y;
        y = {x[84:0], x[95:85]} ^ (x >> 5) ^ 96'h9E3779B9_7F4A7C15_F39CC060;
        return y + {x[31:0], x[95:32]};
    endfunction

    // Byte-level sponge model: pad, split into 12-byte blocks, chain the state.
    task automatic model_msg(input byte_q_t m, input bit done);
        int          len;
        int          nblk;
        logic [7:0]  p[$];
        logic [95:0] st;
        logic [95:0] blk;
        len  = m.size();
        nblk = len / 12 + 1;
        p    = {};
        for (int i = 0; i < nblk * 12; i++) p.push_back(i < len ? m[i] : 8'h00);
        p[len]        = p[len] ^ 8'h01;
        p[nblk*12-1]  = p[nblk*12-1] ^ 8'h80;
        st           = '0;
        model_blocks = {};
        for (int k = 0; k < nblk; k++) begin
            for (int b = 0; b < 12; b++) blk[8*b +: 8] = p[12*k+b];
            model_blocks.push_back(blk);
            exp_perm.push_back(st ^ blk);
            st = perm_f(st ^ blk);
        end
        if (done) begin
            exp_digest.push_back(st);
            exp_len.push_back(32'(len));
        end
    endtask

    // Drive a message as words. Unused bytes of the last word carry garbage.
    // alt selects an extra empty last word for multiple-of-4 lengths.
    task automatic send_msg(input byte_q_t m, input bit alt);
        int len;
        int nwords;
        int last_nb;
        len = m.size();
        if (len == 0) begin
            nwords = 1; last_nb = 0;
        end else if (len % 4 != 0) begin
            nwords = len / 4 + 1; last_nb = len % 4;
        end else if (alt) begin
            nwords = len / 4 + 1; last_nb = 0;
        end else begin
            nwords = len / 4; last_nb = 4;
        end
        for (int w = 0; w < nwords; w++) begin
            logic [31:0] word;
            bit          last;
            int          wait_n;
            last = (w == nwords - 1);
            word = $urandom;
            for (int b = 0; b < 4; b++) if (4*w + b < len) word[8*b +: 8] = m[4*w+b];
            if (gaps_en && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            in_valid  = 1'b1;
            in_data   = word;
            in_last   = last;
            if (last) in_nbytes = (last_nb == 4) ? 3'($urandom_range(4, 7)) : 3'(last_nb);
            else      in_nbytes = 3'($urandom_range(0, 7));
            wait_n = 0;
            while (!in_ready && wait_n < 200) begin
                @(negedge clk);
                wait_n++;
            end
            if (!in_ready) check("in_ready_timeout", in_ready, 1);
            @(negedge clk);
            if (last || (w % 3) == 2) begin
                check("issue_dv", perm_dv, 1);
                check("issue_ready_low", in_ready, 0);
                check("busy_running", busy, 1);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Permutation core stand-in: capture on perm_dv, answer core_lat cycles later.
    initial begin : core
        logic [95:0] cap;
        forever begin
            @(negedge clk);
            if (perm_dv) begin
                cap = perm_state;
                repeat (core_lat) @(negedge clk);
                perm_out       = perm_f(cap);
                perm_out_valid = 1'b1;
                pov_time       = $time;
                @(negedge clk);
                perm_out_valid = 1'b0;
            end
        end
    end

    // Compare process: every launch and every digest against the model queues.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (perm_dv) begin
                if (exp_perm.size() == 0) check("perm_dv_spurious", perm_dv, 0);
                else check("perm_state", perm_state, exp_perm.pop_front());
            end
            if (digest_valid) begin
                if (exp_digest.size() == 0) begin
                    check("digest_valid_spurious", digest_valid, 0);
                end else begin
                    check("digest", digest, exp_digest.pop_front());
                    check("digest_latency", 96'($time - pov_time), CLK_P);
                    check("busy_done", busy, 0);
`ifdef XOODOO_ABSORB_MSGLEN_EN
                    check("msg_bytes", msg_bytes, exp_len.pop_front());
`else
                    void'(exp_len.pop_front());
`endif
                end
            end
        end
    end

    initial begin : watchdog
        #(CLK_P * 60000);
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        byte_q_t m;
        int      wait_n;
        rst_n = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; in_nbytes = '0;
        perm_out = '0; perm_out_valid = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_in_ready", in_ready, 0);
        check("reset_perm_dv", perm_dv, 0);
        check("reset_perm_state", perm_state, 0);
        check("reset_digest", digest, 0);
        check("reset_digest_valid", digest_valid, 0);
        check("reset_busy", busy, 0);
`ifdef XOODOO_ABSORB_MSGLEN_EN
        check("reset_msg_bytes", msg_bytes, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", in_ready, 1);

        // Empty message.
        m = {};
        model_msg(m, 1);
        check("pin_empty_block", model_blocks[0], 96'h80000000_00000000_00000001);
        send_msg(m, 0);

        // "abc".
        m = {8'h61, 8'h62, 8'h63};
        model_msg(m, 1);
        check("pin_abc_block", model_blocks[0], 96'h80000000_00000000_01636261);
        send_msg(m, 0);

        // Eleven bytes: byte 11 becomes 8'h81.
        m = {};
        for (int i = 0; i < 11; i++) m.push_back(8'(i));
        model_msg(m, 1);
        check("pin_eleven_block", model_blocks[0], 96'h810A0908_07060504_03020100);
        check("pin_eleven_nblk", 96'(model_blocks.size()), 1);
        send_msg(m, 0);

        // Exactly twelve bytes: unpadded block then a pure pad block.
        m = {};
        for (int i = 0; i < 12; i++) m.push_back(8'(i));
        model_msg(m, 1);
        check("pin_twelve_second", exp_perm[exp_perm.size()-1],
              perm_f(96'h0B0A0908_07060504_03020100) ^ 96'h80000000_00000000_00000001);
        send_msg(m, 0);

        // Four-word message with in_valid held high throughout.
        m = {};
        for (int i = 0; i < 16; i++) m.push_back(8'($urandom));
        model_msg(m, 1);
        send_msg(m, 0);

        // Reset while waiting on the permutation; the late result must be ignored.
        wait_n = 0;
        while ((exp_digest.size() != 0 || busy) && wait_n < 200) begin
            @(negedge clk);
            wait_n++;
        end
        core_lat = 3;
        m = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
        model_msg(m, 0);
        send_msg(m, 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_in_ready", in_ready, 0);
        check("midreset_digest", digest, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("after_reset_busy", busy, 0);
        core_lat = 1;
        m = {};
        model_msg(m, 1);
        send_msg(m, 0);

        // Randomized messages, core latency and handshake gaps.
        for (int n = 0; n < 40; n++) begin
            int len;
            len      = $urandom_range(0, 40);
            gaps_en  = ($urandom_range(0, 1) == 1);
            core_lat = $urandom_range(1, 3);
            m = {};
            for (int i = 0; i < len; i++) m.push_back(8'($urandom));
            model_msg(m, 1);
            send_msg(m, ($urandom_range(0, 1) == 1));
        end

        wait_n = 0;
        while ((exp_perm.size() != 0 || exp_digest.size() != 0) && wait_n < 500) begin
            @(negedge clk);
            wait_n++;
        end
        repeat (5) @(negedge clk);
        check("perm_left", 96'(exp_perm.size()), 0);
        check("digest_left", 96'(exp_digest.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
